// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: RGB colour-wheel fader.
// A free-running PWM counter drives three LED outputs whose duties walk a
// six-phase hue cycle, stepping the ramp once per PWM period.
// Build option: define LED_ACTIVE_LOW_EN for active-low LED drives
// (inactive level becomes 1, including during reset and while disabled).
module led_fade_ctrl #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned INC_STEP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold,
    input  logic       restart,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] phase,
    output logic       period_tick
);

    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
    localparam logic [DW-1:0] MAX_DUTY = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] LAST_CNT = DW'(PWM_INTERVAL - 1);
    localparam logic [DW:0]   STEP     = (DW + 1)'(INC_STEP);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_OFF = 1'b1;
`else
    localparam logic LED_OFF = 1'b0;
`endif

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0] ramp_q, ramp_d;
    logic [DW-1:0] shadow_r_q, shadow_r_d;
    logic [DW-1:0] shadow_g_q, shadow_g_d;
    logic [DW-1:0] shadow_b_q, shadow_b_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          rgb_r_q, rgb_r_d;
    logic          rgb_g_q, rgb_g_d;
    logic          rgb_b_q, rgb_b_d;

    logic          boundary;
    logic          restart_now;
    logic [DW:0]   ramp_sum;
    logic [DW-1:0] live_r, live_g, live_b;

    assign boundary    = en && (pwm_cnt_q == LAST_CNT);
    assign restart_now = pend_q || restart;
    assign ramp_sum    = {1'b0, ramp_q} + STEP;

    // Live duty table for the current hue phase and ramp position
    always_comb begin
        live_r = '0;
        live_g = '0;
        live_b = '0;
        case (phase_q)
            PH0: begin live_r = MAX_DUTY;          live_g = ramp_q;            live_b = '0;                end
            PH1: begin live_r = MAX_DUTY - ramp_q; live_g = MAX_DUTY;          live_b = '0;                end
            PH2: begin live_r = '0;                live_g = MAX_DUTY;          live_b = ramp_q;            end
            PH3: begin live_r = '0;                live_g = MAX_DUTY - ramp_q; live_b = MAX_DUTY;          end
            PH4: begin live_r = ramp_q;            live_g = '0;                live_b = MAX_DUTY;          end
            PH5: begin live_r = MAX_DUTY;          live_g = '0;                live_b = MAX_DUTY - ramp_q; end
            default: begin live_r = '0;            live_g = '0;                live_b = '0;                end
        endcase
    end

    // Next-state: PWM counter, fade FSM, shadow duties and registered outputs
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q;
        phase_d    = phase_q;
        ramp_d     = ramp_q;
        shadow_r_d = shadow_r_q;
        shadow_g_d = shadow_g_q;
        shadow_b_d = shadow_b_q;
        pend_d     = pend_q || restart;
        tick_d     = boundary;
        rgb_r_d    = LED_OFF;
        rgb_g_d    = LED_OFF;
        rgb_b_d    = LED_OFF;

        if (!en) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = (pwm_cnt_q == LAST_CNT) ? '0 : pwm_cnt_q + 1'b1;
            // Compare uses the current count, so outputs lag pwm_cnt by one clock
            rgb_r_d   = (pwm_cnt_q < shadow_r_q) ^ LED_OFF;
            rgb_g_d   = (pwm_cnt_q < shadow_g_q) ^ LED_OFF;
            rgb_b_d   = (pwm_cnt_q < shadow_b_q) ^ LED_OFF;
        end

        if (boundary) begin
            // Shadows take the pre-update duties; the new phase/ramp show next period
            shadow_r_d = live_r;
            shadow_g_d = live_g;
            shadow_b_d = live_b;
            if (restart_now) begin
                phase_d = PH0;
                ramp_d  = '0;
                pend_d  = 1'b0;
            end else if (!hold) begin
                if (ramp_sum >= (DW + 1)'(PWM_INTERVAL)) begin
                    ramp_d = '0;
                    case (phase_q)
                        PH0:     phase_d = PH1;
                        PH1:     phase_d = PH2;
                        PH2:     phase_d = PH3;
                        PH3:     phase_d = PH4;
                        PH4:     phase_d = PH5;
                        default: phase_d = PH0;
                    endcase
                end else begin
                    ramp_d = ramp_sum[DW-1:0];
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            phase_q    <= PH0;
            ramp_q     <= '0;
            shadow_r_q <= '0;
            shadow_g_q <= '0;
            shadow_b_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            rgb_r_q    <= LED_OFF;
            rgb_g_q    <= LED_OFF;
            rgb_b_q    <= LED_OFF;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            phase_q    <= phase_d;
            ramp_q     <= ramp_d;
            shadow_r_q <= shadow_r_d;
            shadow_g_q <= shadow_g_d;
            shadow_b_q <= shadow_b_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            rgb_r_q    <= rgb_r_d;
            rgb_g_q    <= rgb_g_d;
            rgb_b_q    <= rgb_b_d;
        end
    end

    assign RGB_R       = rgb_r_q;
    assign RGB_G       = rgb_g_q;
    assign RGB_B       = rgb_b_q;
    assign phase       = phase_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl with PWM_INTERVAL=8, INC_STEP=2.
// Duties are measured as on-cycle counts over one full PWM period.
module tb_led_fade_ctrl;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic OFF = 1'b1;
`else
    localparam logic OFF = 1'b0;
`endif
    localparam logic ON = ~OFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       restart = 1'b0;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] phase;
    logic       period_tick;

    int errors = 0;
    int checks = 0;

    led_fade_ctrl #(.PWM_INTERVAL(8), .INC_STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .restart(restart),
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
        .phase(phase), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // Reference duty table for MAX=8
    function automatic void ref_duty(input int ph, input int rp, output int r, output int g, output int b);
        case (ph)
            0: begin r = 8;      g = rp;     b = 0;      end
            1: begin r = 8 - rp; g = 8;      b = 0;      end
            2: begin r = 0;      g = 8;      b = rp;     end
            3: begin r = 0;      g = 8 - rp; b = 8;      end
            4: begin r = rp;     g = 0;      b = 8;      end
            default: begin r = 8; g = 0;     b = 8 - rp; end
        endcase
    endfunction

    // Starting at a negedge on the first cycle of a period, sample 8 negedges;
    // ends on the first cycle of the following period.
    task automatic measure(output int r, output int g, output int b, output int early, output logic last);
        r = 0; g = 0; b = 0; early = 0; last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (RGB_R !== OFF) r++;
            if (RGB_G !== OFF) g++;
            if (RGB_B !== OFF) b++;
            if (i < 7 && period_tick !== 1'b0) early++;
            if (i == 7) last = period_tick;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; hold = 1'b0; restart = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({RGB_R, RGB_G, RGB_B, period_tick, phase} !== {OFF, OFF, OFF, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got rgb=%b%b%b tick=%b phase=%0d, exp rgb=%b%b%b tick=0 phase=0",
                     RGB_R, RGB_G, RGB_B, period_tick, phase, OFF, OFF, OFF);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({RGB_R, RGB_G, RGB_B, period_tick} !== {OFF, OFF, OFF, 1'b0}) begin
            errors++;
            $display("FAIL idle_disabled: got rgb=%b%b%b tick=%b, exp rgb=%b%b%b tick=0",
                     RGB_R, RGB_G, RGB_B, period_tick, OFF, OFF, OFF);
        end
    endtask

    task automatic test_startup;
        int r, g, b, early;
        logic last;
        en = 1'b1;
        measure(r, g, b, early, last);
        checks++;
        if ({r, g, b} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL startup_p1_duty: got r=%0d g=%0d b=%0d, exp 0 0 0", r, g, b);
        end
        checks++;
        if (early !== 0 || last !== 1'b1) begin
            errors++;
            $display("FAIL startup_p1_tick: got early=%0d last=%b, exp early=0 last=1", early, last);
        end
        measure(r, g, b, early, last);
        checks++;
        if ({r, g, b} !== {32'd8, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL startup_p2_duty: got r=%0d g=%0d b=%0d, exp 8 0 0", r, g, b);
        end
        checks++;
        if (early !== 0 || last !== 1'b1 || phase !== 3'd0) begin
            errors++;
            $display("FAIL startup_p2_tick: got early=%0d last=%b phase=%0d, exp 0 1 0", early, last, phase);
        end
    endtask

    // Periods 3..26: duty of period k comes from the state before boundary k-1
    task automatic test_fade;
        int r, g, b, early, er, eg, eb, j;
        logic last;
        for (int k = 3; k <= 26; k++) begin
            j = k - 2;
            ref_duty((j / 4) % 6, 2 * (j % 4), er, eg, eb);
            measure(r, g, b, early, last);
            checks++;
            if (r !== er || g !== eg || b !== eb) begin
                errors++;
                $display("FAIL fade_duty_p%0d: got r=%0d g=%0d b=%0d, exp %0d %0d %0d", k, r, g, b, er, eg, eb);
            end
            checks++;
            if (phase !== 3'((k / 4) % 6)) begin
                errors++;
                $display("FAIL fade_phase_p%0d: got %0d, exp %0d", k, phase, (k / 4) % 6);
            end
            checks++;
            if (early !== 0 || last !== 1'b1) begin
                errors++;
                $display("FAIL fade_tick_p%0d: got early=%0d last=%b, exp 0 1", k, early, last);
            end
        end
    endtask

    // State is PH0/ramp4 with shadows from PH0/ramp2
    task automatic test_hold;
        int r, g, b, early, eg;
        logic last;
        hold = 1'b1;
        for (int k = 27; k <= 30; k++) begin
            eg = (k == 27) ? 2 : 4;
            measure(r, g, b, early, last);
            checks++;
            if (r !== 8 || g !== eg || b !== 0 || phase !== 3'd0) begin
                errors++;
                $display("FAIL hold_p%0d: got r=%0d g=%0d b=%0d phase=%0d, exp 8 %0d 0 phase=0", k, r, g, b, phase, eg);
            end
            checks++;
            if (early !== 0 || last !== 1'b1) begin
                errors++;
                $display("FAIL hold_tick_p%0d: got early=%0d last=%b, exp 0 1", k, early, last);
            end
        end
        hold = 1'b0;
        for (int k = 31; k <= 40; k++) measure(r, g, b, early, last);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL reach_ph3: got phase=%0d, exp 3", phase);
        end
    endtask

    // Restart pulse in PH3 with hold, then an en=0 gap before the boundary
    task automatic test_restart_gap;
        int r, g, b, early;
        logic last;
        hold = 1'b1;
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({RGB_R, RGB_G, RGB_B} !== {OFF, OFF, OFF}) begin
            errors++;
            $display("FAIL en_off_outputs: got rgb=%b%b%b, exp %b%b%b", RGB_R, RGB_G, RGB_B, OFF, OFF, OFF);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (phase !== 3'd3 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_off_frozen: got phase=%0d tick=%b, exp 3 0", phase, period_tick);
        end
        en = 1'b1;
        measure(r, g, b, early, last);
        checks++;
        if (r !== 0 || g !== 8 || b !== 6) begin
            errors++;
            $display("FAIL resume_duty: got r=%0d g=%0d b=%0d, exp 0 8 6", r, g, b);
        end
        checks++;
        if (early !== 0 || last !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick: got early=%0d last=%b, exp 0 1", early, last);
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL restart_phase: got %0d, exp 0", phase);
        end
        measure(r, g, b, early, last);
        checks++;
        if (r !== 0 || g !== 8 || b !== 8 || phase !== 3'd0) begin
            errors++;
            $display("FAIL restart_shadow: got r=%0d g=%0d b=%0d phase=%0d, exp 0 8 8 0", r, g, b, phase);
        end
        measure(r, g, b, early, last);
        checks++;
        if (r !== 8 || g !== 0 || b !== 0 || phase !== 3'd0) begin
            errors++;
            $display("FAIL restart_ramp0: got r=%0d g=%0d b=%0d phase=%0d, exp 8 0 0 0", r, g, b, phase);
        end
    endtask

    // Red is constantly on (PH0 ramp 0 held); reset lands between clock edges
    task automatic test_async_reset;
        int r, g, b, early;
        logic last;
        repeat (2) @(negedge clk);
        checks++;
        if (RGB_R !== ON) begin
            errors++;
            $display("FAIL pre_reset_red: got %b, exp %b", RGB_R, ON);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({RGB_R, RGB_G, RGB_B, period_tick, phase} !== {OFF, OFF, OFF, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got rgb=%b%b%b tick=%b phase=%0d, exp %b%b%b 0 0",
                     RGB_R, RGB_G, RGB_B, period_tick, phase, OFF, OFF, OFF);
        end
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        measure(r, g, b, early, last);
        checks++;
        if (r !== 0 || g !== 0 || b !== 0 || early !== 0 || last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_p1: got r=%0d g=%0d b=%0d early=%0d last=%b, exp 0 0 0 0 1", r, g, b, early, last);
        end
        measure(r, g, b, early, last);
        checks++;
        if (r !== 8 || g !== 0 || b !== 0) begin
            errors++;
            $display("FAIL post_reset_p2: got r=%0d g=%0d b=%0d, exp 8 0 0", r, g, b);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_fade();
        test_hold();
        test_restart_gap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
